tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 SHALL have parameter BW, default 24: width of all counters and measurement outputs.
REQ-002 SHALL have parameter TIMEOUT, default 24'd2400000: clock cycles without a rising edge before the input is declared silent.
REQ-003 SHALL have parameter STABLE_CNT, default 4: consecutive matching measurements required for stable_o.
REQ-004 SHALL have parameter TOL, default 2: maximum absolute period difference, in clocks, that still counts as matching.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port sound_i, input, 1 bit: asynchronous square or PWM audio input, the tone stream produced by the sound generator.
REQ-008 SHALL have port period_o, output, BW bits: last measured period, rising edge to rising edge, in clocks.
REQ-009 SHALL have port high_o, output, BW bits: high time within that period, in clocks.
REQ-010 SHALL have port valid_o, output, 1 bit: single-cycle pulse when period_o and high_o update.
REQ-011 SHALL have port stable_o, output, 1 bit: level; the tone is steady.
REQ-012 SHALL have port timeout_o, output, 1 bit: level; no tone is present.

Function
REQ-013 SHALL pass sound_i through a 2-flop synchronizer, then a third flop, for edge detection; rising edge = sync2 high and prev low; falling edge = the reverse.
REQ-014 SHALL implement FSM WAIT_EDGE -> MEASURE.
- WAIT_EDGE -> MEASURE on the first rising edge.
- MEASURE -> WAIT_EDGE on timeout.
REQ-015 SHALL, on any rising edge, load the period counter with 1 and the high counter with 1; otherwise the period counter increments by 1 per clock.
REQ-016 SHALL increment the high counter only while sync2 is high and no falling edge has occurred since the last rising edge; it freezes after the falling edge.
REQ-017 SHALL, on a rising edge in MEASURE, capture period counter -> period_o and high counter -> high_o, and pulse valid_o high for exactly one cycle, registered together with the capture.
REQ-018 SHALL make valid_o high in the cycle following the 3rd rising clk_i edge counted from the edge that first samples sound_i high; this 3-cycle latency is fixed.
REQ-019 SHALL NOT pulse valid_o on the rising edge that causes WAIT_EDGE -> MEASURE; that edge only starts counting.
REQ-020 SHALL declare timeout when the period counter equals TIMEOUT in MEASURE with no rising edge that cycle.
- Next cycle: state WAIT_EDGE, timeout_o = 1, period_o = 0, high_o = 0, stable_o = 0, match counter = 0.
REQ-021 SHALL let the rising edge win when a rising edge and timeout coincide: normal capture, no timeout.
REQ-022 SHALL clear timeout_o on the first rising edge after timeout, in the same cycle the state enters MEASURE.
REQ-023 SHALL hold the period counter at TIMEOUT in WAIT_EDGE, so it never wraps; TIMEOUT < 2^BW is required.
REQ-024 SHALL compare each new capture with the previous period_o: |new - old| <= TOL increments a match counter saturating at STABLE_CNT; otherwise the match counter resets to 0.
REQ-025 SHALL assert stable_o when the match counter equals STABLE_CNT, updated in the same cycle as valid_o.
REQ-026 SHALL compute the period difference at BW+1 bits, with no overflow.
REQ-027 SHALL ignore pulses shorter than the synchronizer resolution; no glitch filter is required.

Reset
REQ-028 SHALL, while rst_i is high, asynchronously force:
- state WAIT_EDGE, synchronizer flops 0;
- counters 0, period_o 0, high_o 0, valid_o 0, stable_o 0;
- timeout_o 1.
REQ-029 SHALL, on reset mid-measurement, discard the partial measurement; after release, the first rising edge only restarts counting.

Verification
REQ-030 SHALL cover this scenario:
- Stimulus: reset, then square wave of period 125 clocks, 63 high.
- Response: no valid_o on the 1st edge; valid_o on the 2nd and later edges with period_o = 125 and high_o = 63; timeout_o falls at the 1st edge.
REQ-031 SHALL cover this scenario:
- Stimulus: 6 periods of 125, 124, 126, 125, 125, 125.
- Response: stable_o = 1 from the 5th valid_o onward.
- Stimulus: then one period of 200.
- Response: stable_o = 0 at that capture.
REQ-032 SHALL cover this scenario:
- Stimulus: TIMEOUT = 1000, tone period 100, then sound_i held low.
- Response: timeout_o = 1, period_o = 0, stable_o = 0 exactly 1000 clocks after the last rising edge.
- Stimulus: the next edge.
- Response: no valid_o; the following edge gives valid_o.
REQ-033 SHALL cover this scenario:
- Stimulus: a rising edge arrives on the cycle the counter reaches TIMEOUT.
- Response: valid_o with period_o = TIMEOUT; timeout_o stays 0.
REQ-034 SHALL cover this scenario:
- Stimulus: rst_i pulsed mid-period.
- Response: all outputs at reset values immediately, without waiting for a clock edge; the next period is captured only after two post-reset edges.
REQ-035 SHALL cover this scenario:
- Stimulus: duty extremes, period 20 with high 1 and period 20 with high 19.
- Response: high_o = 1 and high_o = 19 respectively; period_o = 20.

Source files
------------

// File: rtl/tone_decoder.sv
// tone_decoder: measures period and high time of an asynchronous square/PWM
// tone, flags when consecutive periods agree (stable) and when no edge has
// been seen for TIMEOUT clocks (silence).
//
// Ports:
//   clk_i     - clock, all state on rising edge
//   rst_i     - asynchronous active-high reset
//   sound_i   - asynchronous tone input
//   period_o  - last measured period (rising edge to rising edge), clocks
//   high_o    - high time within that period, clocks
//   valid_o   - one-cycle pulse when period_o/high_o update
//   stable_o  - STABLE_CNT consecutive captures within TOL of each other
//   timeout_o - no tone present
module tone_decoder #(
  parameter int            BW         = 24,
  parameter logic [BW-1:0] TIMEOUT    = 24'd2400000,
  parameter int            STABLE_CNT = 4,
  parameter int            TOL        = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sound_i,
  output logic [BW-1:0] period_o,
  output logic [BW-1:0] high_o,
  output logic          valid_o,
  output logic          stable_o,
  output logic          timeout_o
);

  localparam int MW = $clog2(STABLE_CNT + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_CNT);
  localparam logic [BW:0]   TOL_W     = (BW+1)'(TOL);

  typedef enum logic {WAIT_EDGE, MEASURE} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, prev_q;
  logic [BW-1:0] per_cnt_q, per_cnt_d;
  logic [BW-1:0] hi_cnt_q, hi_cnt_d;
  logic          hi_run_q, hi_run_d;
  logic [BW-1:0] period_q, period_d;
  logic [BW-1:0] high_q, high_d;
  logic          valid_q, valid_d;
  logic          stable_q, stable_d;
  logic          tmo_q, tmo_d;
  logic [MW-1:0] match_q, match_d;

  logic          rise, fall;
  logic [BW:0]   diff, adiff;

  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

  // One extra bit so the difference of two BW-bit periods never overflows;
  // the sign bit selects two's-complement negation for the magnitude.
  assign diff  = {1'b0, per_cnt_q} - {1'b0, period_q};
  assign adiff = diff[BW] ? (~diff + 1'b1) : diff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= WAIT_EDGE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      prev_q    <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      hi_run_q  <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stable_q  <= 1'b0;
      tmo_q     <= 1'b1;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= sound_i;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      hi_run_q  <= hi_run_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      stable_q  <= stable_d;
      tmo_q     <= tmo_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q + 1'b1;
    hi_cnt_d  = hi_cnt_q;
    hi_run_d  = hi_run_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    stable_d  = stable_q;
    tmo_d     = tmo_q;
    match_d   = match_q;

    // Counters restart on every rising edge; high time freezes at the fall.
    if (rise) begin
      per_cnt_d = {{(BW-1){1'b0}}, 1'b1};
      hi_cnt_d  = {{(BW-1){1'b0}}, 1'b1};
      hi_run_d  = 1'b1;
    end else if (fall) begin
      hi_run_d  = 1'b0;
    end else if (hi_run_q && s2_q) begin
      hi_cnt_d  = hi_cnt_q + 1'b1;
    end

    case (state_q)
      WAIT_EDGE: begin
        if (rise) begin
          // First edge only starts counting; nothing to capture yet.
          state_d = MEASURE;
          tmo_d   = 1'b0;
        end else begin
          per_cnt_d = TIMEOUT;  // parked so it can never wrap while idle
        end
      end
      MEASURE: begin
        if (rise) begin
          // Rising edge beats a coincident timeout.
          period_d = per_cnt_q;
          high_d   = hi_cnt_q;
          valid_d  = 1'b1;
          if (adiff <= TOL_W) begin
            if (match_q < MATCH_MAX) match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
          end
          stable_d = (match_d == MATCH_MAX);
        end else if (per_cnt_q == TIMEOUT) begin
          state_d   = WAIT_EDGE;
          tmo_d     = 1'b1;
          period_d  = '0;
          high_d    = '0;
          stable_d  = 1'b0;
          match_d   = '0;
          per_cnt_d = TIMEOUT;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign stable_o  = stable_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder. The reference model works on the
// timeline of sound_i as driven: a rising edge driven in cycle c becomes a
// capture visible 3 cycles later, with period = c - previous rise and high =
// fall - previous rise. Silence longer than TIMEOUT is a timeout.
module tb_tone_decoder;
  localparam int BW  = 24;
  localparam int TMO = 1000;
  localparam int STB = 4;
  localparam int TL  = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          sound_i = 1'b0;
  logic [BW-1:0] period_o, high_o;
  logic          valid_o, stable_o, timeout_o;

  tone_decoder #(.BW(BW), .TIMEOUT(24'd1000), .STABLE_CNT(STB), .TOL(TL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sound_i(sound_i),
    .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
    .stable_o(stable_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 capture, 1 timeout, 2 start (first edge after silence)
  typedef struct {int t; int kind; int per; int hi;} ev_t;
  ev_t evq[$];

  int cyc = 0, checks = 0, errors = 0;
  // drive-side model state
  bit m_cur, m_meas;
  int m_lr, m_lf;
  // visible-side expected outputs
  int e_period, e_high, e_match;
  bit e_valid, e_stable, e_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid",   32'(valid_o),   32'(e_valid));
    chk("period",  32'(period_o),  32'(e_period));
    chk("high",    32'(high_o),    32'(e_high));
    chk("stable",  32'(stable_o),  32'(e_stable));
    chk("timeout", 32'(timeout_o), 32'(e_tmo));
  endtask

  task automatic model_reset();
    evq.delete();
    m_cur = 0; m_meas = 0; m_lr = 0; m_lf = 0;
    e_period = 0; e_high = 0; e_match = 0;
    e_valid = 0; e_stable = 0; e_tmo = 1;
  endtask

  task automatic apply(input ev_t e);
    int d;
    case (e.kind)
      0: begin
        d = e.per - e_period;
        if (d < 0) d = -d;
        if (d <= TL) e_match = (e_match < STB) ? e_match + 1 : STB;
        else         e_match = 0;
        e_stable = (e_match == STB);
        e_period = e.per;
        e_high   = e.hi;
        e_valid  = 1;
      end
      1: begin
        e_tmo = 1; e_period = 0; e_high = 0; e_stable = 0; e_match = 0;
      end
      default: e_tmo = 0;
    endcase
  endtask

  task automatic step(input bit v);
    ev_t e;
    @(posedge clk_i);
    cyc++;
    #1;
    e_valid = 0;
    while (evq.size() > 0 && evq[0].t == cyc) apply(evq.pop_front());
    check_all();
    // silence longer than TIMEOUT since the last driven rise
    if (m_meas && (cyc - m_lr > TMO)) begin
      e = '{t: cyc + 2, kind: 1, per: 0, hi: 0};
      evq.push_back(e);
      m_meas = 0;
    end
    if (v && !m_cur) begin
      if (m_meas) e = '{t: cyc + 3, kind: 0, per: cyc - m_lr, hi: m_lf - m_lr};
      else        e = '{t: cyc + 3, kind: 2, per: 0, hi: 0};
      evq.push_back(e);
      m_meas = 1;
      m_lr = cyc;
    end else if (!v && m_cur) begin
      m_lf = cyc;
    end
    m_cur = v;
    sound_i = v;
  endtask

  task automatic tone(input int p, input int h);
    for (int i = 0; i < h; i++) step(1'b1);
    for (int i = 0; i < p - h; i++) step(1'b0);
  endtask

  // Reset asserted between clock edges: outputs must change without a clock.
  task automatic do_reset();
    @(negedge clk_i);
    sound_i = 1'b0;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) step(1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) step(1'b0);
  endtask

  initial begin
    int p, h;
    model_reset();
    do_reset();

    // steady 125/63 tone
    repeat (4) tone(125, 63);

    // near-equal periods build stability, then a jump breaks it
    tone(125, 60); tone(124, 60); tone(126, 60);
    tone(125, 60); tone(125, 60); tone(125, 60);
    tone(200, 60);
    tone(200, 60);

    // silence after a 100-clock tone, then restart
    repeat (4) tone(100, 50);
    repeat (1100) step(1'b0);
    repeat (3) tone(100, 50);

    // period exactly TIMEOUT captures; TIMEOUT+1 times out
    tone(TMO, 500); tone(TMO, 500);
    tone(TMO + 1, 500);
    repeat (2) tone(100, 50);

    // reset in the middle of a high phase
    repeat (30) step(1'b1);
    do_reset();
    repeat (3) tone(100, 40);

    // duty extremes
    repeat (3) tone(20, 1);
    repeat (3) tone(20, 19);

    // random periods, some straddling the timeout boundary
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 4) == 0) p = int'($urandom_range(TMO - 5, TMO + 5));
      else                           p = int'($urandom_range(3, 300));
      h = int'($urandom_range(1, p - 1));
      tone(p, h);
    end
    repeat (1100) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
